mem_bus_arbiter: RTL and testbench

- Shares the single cache/memory bus (cbus) between the instruction-fetch port (ibus) and the memory-stage data port (dbus).
- Grants one requester at a time, latches its request, and issues one single-beat cbus transaction.
- Returns the beat to the granted requester as a one-cycle data_ok pulse.
- Sits between the core pipeline (fetch and memory stages) and the top-level memory interface.

---
 rtl/mem_bus_arbiter_pkg.sv | 44 ++++
 rtl/mem_bus_arbiter_if.sv | 12 +
 rtl/mem_bus_arbiter_arb_pick.sv | 18 +
 rtl/mem_bus_arbiter.sv | 73 +++++++
 tb/tb_mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared ibus/dbus/cbus types and arbiter enums
package mem_bus_arbiter_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP} axi_burst_type_t;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [31:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data and shared cache bus signals of the arbiter
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  modport master (input ireq, dreq, oresp, output iresp, dresp, oreq);
  modport slave (output ireq, dreq, oresp, input iresp, dresp, oreq);
endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// arb_pick: grant selection; round-robin when MEM_BUS_ARB_RR_EN is defined, else data over fetch
module arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic       ivalid,
  input  logic       dvalid,
`ifdef MEM_BUS_ARB_RR_EN
  input  arb_grant_t last_grant,
`endif
  output arb_grant_t grant
);
`ifdef MEM_BUS_ARB_RR_EN
  assign grant = (ivalid && dvalid) ? (last_grant == GRANT_I ? GRANT_D : GRANT_I)
                                    : (ivalid ? GRANT_I : GRANT_D);
`else
  assign grant = (ivalid && !dvalid) ? GRANT_I : GRANT_D;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-beat cbus between ibus and dbus
// Optional round-robin arbitration via MEM_BUS_ARB_RR_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.master bus
);
  arb_state_t state, state_n;
  arb_grant_t grant;
  cbus_req_t  saved, grant_req;
  logic       take, busy, done;
`ifdef MEM_BUS_ARB_RR_EN
  arb_grant_t last_grant;
  arb_pick u_pick (.ivalid(bus.ireq.valid), .dvalid(bus.dreq.valid), .last_grant(last_grant), .grant(grant));
  always_ff @(posedge clk) begin
    if (reset) last_grant <= GRANT_I;
    else if (take) last_grant <= grant;
  end
`else
  arb_pick u_pick (.ivalid(bus.ireq.valid), .dvalid(bus.dreq.valid), .grant(grant));
`endif
  assign take = state == IDLE && (bus.ireq.valid || bus.dreq.valid);
  assign busy = state == BUSY_I || state == BUSY_D;
  assign done = busy && bus.oresp.ready && bus.oresp.last;
  always_comb begin
    grant_req = '0;
    grant_req.valid = 1'b1;
    grant_req.len = MLEN1;
    grant_req.burst = AXI_BURST_FIXED;
    grant_req.is_write = grant == GRANT_D && |bus.dreq.strobe;
    grant_req.size = grant == GRANT_D ? bus.dreq.size : MSIZE4;
    grant_req.addr = grant == GRANT_D ? bus.dreq.addr : bus.ireq.addr;
    grant_req.strobe = grant == GRANT_D ? bus.dreq.strobe : 8'h00;
    grant_req.data = grant == GRANT_D ? bus.dreq.data : 64'h0;
  end
  // GAP blocks a re-grant to a requester whose valid is still high at completion
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = take ? (grant == GRANT_D ? BUSY_D : BUSY_I) : IDLE;
    else if (busy) state_n = done ? (IDLE_GAP != 0 ? GAP : IDLE) : state;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      saved <= '0;
    end else begin
      state <= state_n;
      if (take) saved <= grant_req;
    end
  end
  // a requester that dropped valid mid-flight still completes on cbus but gets no response
  always_comb begin
    bus.oreq = '0;
    bus.iresp = '0;
    bus.dresp = '0;
    if (busy) bus.oreq = saved;
    if (done && state == BUSY_I && bus.ireq.valid) begin
      bus.iresp.addr_ok = 1'b1;
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data = saved.addr[2] ? bus.oresp.data[63:32] : bus.oresp.data[31:0];
    end
    if (done && state == BUSY_D && bus.dreq.valid) begin
      bus.dresp.addr_ok = 1'b1;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data = bus.oresp.data;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;
  typedef struct packed {
    logic        is_d;
    logic [63:0] data;
  } resp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_bus_arbiter_if bus();
  mem_bus_arbiter #(.IDLE_GAP(1)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  cbus_req_t exp_req[$];
  resp_t     exp_resp[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit slow = 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
  arb_grant_t last = GRANT_I;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return a == 32'h8000_0004 ? 64'h1111_2222_3333_4444 : {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  function automatic cbus_req_t build_i(input logic [31:0] a);
    cbus_req_t c = '0;
    c.valid = 1'b1;
    c.size = MSIZE4;
    c.addr = a;
    c.len = MLEN1;
    c.burst = AXI_BURST_FIXED;
    return c;
  endfunction

  function automatic cbus_req_t build_d(input dbus_req_t d);
    cbus_req_t c = '0;
    c.valid = 1'b1;
    c.is_write = d.strobe != 8'h00;
    c.size = d.size;
    c.addr = d.addr;
    c.strobe = d.strobe;
    c.data = d.data;
    c.len = MLEN1;
    c.burst = AXI_BURST_FIXED;
    return c;
  endfunction

  initial begin : monitor
    cbus_req_t cur;
    resp_t r;
    bit have = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) have = 1'b0;
      else begin
        if (bus.oreq.valid) begin
          if (!have) cur = exp_req.size() != 0 ? exp_req.pop_front() : '0;
          have = 1'b1;
          check("oreq", 128'(bus.oreq), 128'(cur));
          if (bus.oresp.ready && bus.oresp.last) have = 1'b0;
        end
        if (bus.iresp.data_ok || bus.dresp.data_ok) begin
          if (exp_resp.size() == 0) check("unexpected_data_ok", 128'({bus.iresp.data_ok, bus.dresp.data_ok}), 128'(0));
          else begin
            r = exp_resp.pop_front();
            check("resp_port", 128'({bus.iresp.data_ok, bus.dresp.data_ok}), 128'(r.is_d ? 2'b01 : 2'b10));
            check("resp_addr_ok", 128'({bus.iresp.addr_ok, bus.dresp.addr_ok}), 128'(r.is_d ? 2'b01 : 2'b10));
            check("resp_data", 128'(r.is_d ? bus.dresp.data : {32'h0, bus.iresp.data}), 128'(r.data));
          end
        end
      end
    end
  end

  // memory: random latency with stray ready-without-last beats, then one ready+last beat
  initial begin : memory
    int lat;
    bus.oresp = '0;
    forever begin
      @(posedge clk); #1;
      bus.oresp = '0;
      if (bus.oreq.valid && !reset) begin
        lat = slow ? 10 : int'($urandom_range(0, 3));
        repeat (lat) begin
          bus.oresp.ready = $urandom_range(0, 3) == 0;
          bus.oresp.last = 1'b0;
          bus.oresp.data = {$urandom, $urandom};
          @(posedge clk); #1;
        end
        bus.oresp.ready = 1'b1;
        bus.oresp.last = 1'b1;
        bus.oresp.data = mem_word(bus.oreq.addr);
      end
    end
  end

  task automatic round(input bit iv, input bit dv, input logic [31:0] ia, input dbus_req_t d);
    arb_grant_t first;
    bit ipend = iv, dpend = dv, idone, ddone, wiggle;
    int n = 0;
    logic [63:0] w = mem_word(ia);
    resp_t ri = '{is_d: 1'b0, data: {32'h0, ia[2] ? w[63:32] : w[31:0]}};
    resp_t rd = '{is_d: 1'b1, data: mem_word(d.addr)};
`ifdef MEM_BUS_ARB_RR_EN
    first = (iv && dv) ? (last == GRANT_I ? GRANT_D : GRANT_I) : (dv ? GRANT_D : GRANT_I);
    last = (iv && dv) ? (first == GRANT_D ? GRANT_I : GRANT_D) : first;
`else
    first = dv ? GRANT_D : GRANT_I;
`endif
    if (first == GRANT_D) begin
      if (dv) begin exp_req.push_back(build_d(d)); exp_resp.push_back(rd); end
      if (iv) begin exp_req.push_back(build_i(ia)); exp_resp.push_back(ri); end
    end else begin
      if (iv) begin exp_req.push_back(build_i(ia)); exp_resp.push_back(ri); end
      if (dv) begin exp_req.push_back(build_d(d)); exp_resp.push_back(rd); end
    end
    wiggle = iv && dv && first == GRANT_D;
    bus.ireq.valid = iv;
    bus.ireq.addr = ia;
    bus.dreq = d;
    bus.dreq.valid = dv;
    while ((ipend || dpend) && n < 100) begin
      @(negedge clk);
      n++;
      idone = ipend && bus.iresp.data_ok;
      ddone = dpend && bus.dresp.data_ok;
      @(posedge clk); #1;
      if (idone) begin ipend = 1'b0; bus.ireq.valid = 1'b0; end
      if (ddone) begin dpend = 1'b0; bus.dreq.valid = 1'b0; bus.ireq.addr = ia; end
      else if (wiggle && dpend) bus.ireq.addr = $urandom;
    end
    if (ipend || dpend) check("round_timeout", 128'({ipend, dpend}), 128'(0));
    bus.ireq.valid = 1'b0;
    bus.dreq.valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    dbus_req_t d;
    logic [1:0] pat;
    int n;
    bus.ireq = '0;
    bus.dreq = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    check("reset_iresp", 128'(bus.iresp), 128'(0));
    check("reset_dresp", 128'(bus.dresp), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    d = '{valid: 1'b1, addr: 32'h8000_1000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    round(1'b1, 1'b0, 32'h8000_0004, d);
    round(1'b1, 1'b1, 32'h8000_0010, d);
    round(1'b0, 1'b1, 32'h0, '{valid: 1'b1, addr: 32'h8000_2008, size: MSIZE4, strobe: 8'h0F, data: 64'hDEAD_BEEF});
    round(1'b1, 1'b1, 32'h8000_0020, d);
    round(1'b1, 1'b1, 32'h8000_0024, '{valid: 1'b1, addr: 32'h8000_3000, size: MSIZE2, strobe: 8'h00, data: 64'h0});
    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(1, 3));
      d.valid = 1'b1;
      d.addr = $urandom;
      d.size = msize_t'($urandom_range(0, 3));
      d.strobe = $urandom_range(0, 1) != 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      d.data = {$urandom, $urandom};
      round(pat[0], pat[1], $urandom, d);
    end
    // abort a data transaction with reset two cycles into its grant
    slow = 1'b1;
    d = '{valid: 1'b1, addr: 32'h8000_4000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    exp_req.push_back(build_d(d));
    bus.dreq = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.oreq.valid && n < 20);
    check("abort_grant_seen", 128'(bus.oreq.valid), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.dreq.valid = 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
    last = GRANT_I;
`endif
    @(negedge clk);
    check("abort_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    repeat (14) begin
      check("abort_no_data_ok", 128'({bus.iresp.data_ok, bus.dresp.data_ok}), 128'(0));
      @(negedge clk);
    end
    slow = 1'b0;
    repeat (3) @(posedge clk);
    check("post_reset_fetch_ok", 128'(1), 128'(1) & 128'(!bus.oreq.valid));
    round(1'b1, 1'b0, 32'h8000_0004, d);
    round(1'b1, 1'b1, 32'h8000_0040, d);
    check("exp_req_drained", 128'(exp_req.size()), 128'(0));
    check("exp_resp_drained", 128'(exp_resp.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
